rwt_up_arbiter: RTL

- Shares one up register-bus slave port (write and read channels) among NUM_MASTERS requesters, e.g. the AXI-to-up bridge plus internal sequencers.
- Latches single-cycle request pulses and serves them round-robin, one transaction at a time.
- Forwards each transaction to the shared slave and routes the slave's ack and read data back to the owning master.
- Sits between the masters and the register demux that fans the bus out to sub-blocks.

---
 rtl/rwt_up_arbiter.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/rwt_up_arbiter.sv
// Round-robin arbiter sharing one up register-bus slave among NUM_MASTERS requesters.
// Define RWT_UP_ARB_TIMEOUT_EN to force completion after TIMEOUT_CYCLES WAIT cycles.
module rwt_up_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int AW             = 14,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      up_clk,
    input  logic                      up_rst,
    input  logic [NUM_MASTERS-1:0]    m_wreq,
    input  logic [NUM_MASTERS*AW-1:0] m_waddr,
    input  logic [NUM_MASTERS*32-1:0] m_wdata,
    output logic [NUM_MASTERS-1:0]    m_wack,
    input  logic [NUM_MASTERS-1:0]    m_rreq,
    input  logic [NUM_MASTERS*AW-1:0] m_raddr,
    output logic [NUM_MASTERS*32-1:0] m_rdata,
    output logic [NUM_MASTERS-1:0]    m_rack,
    output logic                      s_wreq,
    output logic [AW-1:0]             s_waddr,
    output logic [31:0]               s_wdata,
    input  logic                      s_wack,
    output logic                      s_rreq,
    output logic [AW-1:0]             s_raddr,
    input  logic [31:0]               s_rdata,
    input  logic                      s_rack,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    if (NUM_MASTERS < 1 || NUM_MASTERS > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("rwt_up_arbiter: unsupported parameter set");
    end

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [NUM_MASTERS-1:0]    r_wpend;
    logic [NUM_MASTERS-1:0]    r_rpend;
    logic [IW-1:0]             r_ptr;
    logic [IW-1:0]             r_grant;
    logic                      r_chan_wr;
    logic                      r_s_wreq;
    logic                      r_s_rreq;
    logic [AW-1:0]             r_s_waddr;
    logic [31:0]               r_s_wdata;
    logic [AW-1:0]             r_s_raddr;
    logic [NUM_MASTERS-1:0]    r_m_wack;
    logic [NUM_MASTERS-1:0]    r_m_rack;
    logic [NUM_MASTERS*32-1:0] r_m_rdata;

    logic                      w_found;
    logic [IW-1:0]             w_sel_idx;
    logic                      w_sel_wr;
    logic                      w_issue;
    logic                      w_done;
    logic                      w_tout;
    logic                      w_tmo;
    logic                      w_ack;
    logic [NUM_MASTERS-1:0]    w_wclr;
    logic [NUM_MASTERS-1:0]    w_rclr;

    // Scan from the slot after the last grant, wrapping around.
    always_comb begin
        int p;
        w_found   = 1'b0;
        w_sel_idx = '0;
        w_sel_wr  = 1'b0;
        p         = 0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            p = int'(r_ptr) + k;
            if (p >= NUM_MASTERS) begin
                p = p - NUM_MASTERS;
            end
            if (!w_found && (r_wpend[p] || r_rpend[p])) begin
                w_found   = 1'b1;
                w_sel_idx = IW'(p);
                w_sel_wr  = r_wpend[p];
            end
        end
    end

    assign w_ack = r_chan_wr ? s_wack : s_rack;

    always_ff @(posedge up_clk) begin
        if (up_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_done      = 1'b0;
        w_tout      = 1'b0;
        w_wclr      = '0;
        w_rclr      = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_issue     = 1'b1;
                    w_state_nxt = ST_WAIT;
                    if (w_sel_wr) begin
                        w_wclr[w_sel_idx] = 1'b1;
                    end else begin
                        w_rclr[w_sel_idx] = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (w_ack) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_tmo) begin
                    w_done      = 1'b1;
                    w_tout      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // A pulse on a bit being served in the same cycle is absorbed.
    always_ff @(posedge up_clk) begin
        if (up_rst) begin
            r_wpend   <= '0;
            r_rpend   <= '0;
            r_ptr     <= IW'(NUM_MASTERS - 1);
            r_grant   <= '0;
            r_chan_wr <= 1'b0;
            r_s_wreq  <= 1'b0;
            r_s_rreq  <= 1'b0;
            r_s_waddr <= '0;
            r_s_wdata <= '0;
            r_s_raddr <= '0;
            r_m_wack  <= '0;
            r_m_rack  <= '0;
            r_m_rdata <= '0;
        end else begin
            r_wpend  <= (r_wpend | m_wreq) & ~w_wclr;
            r_rpend  <= (r_rpend | m_rreq) & ~w_rclr;
            r_s_wreq <= w_issue & w_sel_wr;
            r_s_rreq <= w_issue & ~w_sel_wr;
            r_m_wack <= '0;
            r_m_rack <= '0;
            if (w_issue) begin
                r_grant   <= w_sel_idx;
                r_ptr     <= w_sel_idx;
                r_chan_wr <= w_sel_wr;
                if (w_sel_wr) begin
                    r_s_waddr <= m_waddr[w_sel_idx*AW +: AW];
                    r_s_wdata <= m_wdata[w_sel_idx*32 +: 32];
                end else begin
                    r_s_raddr <= m_raddr[w_sel_idx*AW +: AW];
                end
            end
            if (w_done) begin
                if (r_chan_wr) begin
                    r_m_wack[r_grant] <= 1'b1;
                end else begin
                    r_m_rack[r_grant] <= 1'b1;
                    r_m_rdata[r_grant*32 +: 32] <= w_tout ? 32'hDEAD_DEAD : s_rdata;
                end
            end
        end
    end

`ifdef RWT_UP_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] r_tcnt;
    logic          r_timeout_err;

    always_ff @(posedge up_clk) begin
        if (up_rst) begin
            r_tcnt        <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_tout;
            if (w_issue) begin
                r_tcnt <= '0;
            end else if (r_state == ST_WAIT) begin
                r_tcnt <= r_tcnt + 1'b1;
            end
        end
    end

    // Fires on the TIMEOUT_CYCLES-th WAIT cycle without an ack.
    assign w_tmo       = (r_state == ST_WAIT) && (r_tcnt == TW'(TIMEOUT_CYCLES - 1));
    assign timeout_err = r_timeout_err;
`else
    assign w_tmo       = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign busy    = (r_state == ST_WAIT);
    assign s_wreq  = r_s_wreq;
    assign s_rreq  = r_s_rreq;
    assign s_waddr = r_s_waddr;
    assign s_wdata = r_s_wdata;
    assign s_raddr = r_s_raddr;
    assign m_wack  = r_m_wack;
    assign m_rack  = r_m_rack;
    assign m_rdata = r_m_rdata;

endmodule
